// File: rtl/checkpoint_map_table_if.sv
// Rename-side bundle of the checkpointed map table: dispatch lookups/installs,
// CDB snoop, checkpoint control and the debug view of the current map.
interface checkpoint_map_table_if #(
  parameter int WAY    = 3,
  parameter int AR_NUM = 32,
  parameter int PR_W   = 6,
  parameter int CKPT   = 4,
  parameter int CDB_W  = 3
);
  localparam int AR_W  = $clog2(AR_NUM);
  localparam int WAY_W = (WAY > 1) ? $clog2(WAY) : 1;
  localparam int CK_W  = (CKPT > 1) ? $clog2(CKPT) : 1;

  logic [WAY-1:0]                  dispatch_valid_i;
  logic [WAY-1:0][AR_W-1:0]        new_ar_i;
  logic [WAY-1:0][PR_W-1:0]        new_pr_i;
  logic [WAY-1:0][AR_W-1:0]        reg1_ar_i;
  logic [WAY-1:0][AR_W-1:0]        reg2_ar_i;
  logic [WAY-1:0][PR_W-1:0]        reg1_tag_o;
  logic [WAY-1:0][PR_W-1:0]        reg2_tag_o;
  logic [WAY-1:0]                  reg1_ready_o;
  logic [WAY-1:0]                  reg2_ready_o;
  logic [WAY-1:0][PR_W-1:0]        told_out_o;
  logic [CDB_W-1:0][PR_W-1:0]      cdb_tag_i;
  logic                            ckpt_take_i;
  logic [WAY_W-1:0]                ckpt_way_i;
  logic [CK_W-1:0]                 ckpt_id_o;
  logic                            ckpt_full_o;
  logic                            ckpt_release_i;
  logic                            recover_en_i;
  logic [CK_W-1:0]                 recover_id_i;
  logic                            flush_en_i;
  logic [AR_NUM-1:0][PR_W-1:0]     archi_maptable_i;
  logic [AR_NUM-1:0][PR_W-1:0]     map_array_disp_o;
  logic [AR_NUM-1:0]               ready_array_disp_o;

  modport slave (
    input  dispatch_valid_i, new_ar_i, new_pr_i, reg1_ar_i, reg2_ar_i,
           cdb_tag_i, ckpt_take_i, ckpt_way_i, ckpt_release_i,
           recover_en_i, recover_id_i, flush_en_i, archi_maptable_i,
    output reg1_tag_o, reg2_tag_o, reg1_ready_o, reg2_ready_o, told_out_o,
           ckpt_id_o, ckpt_full_o, map_array_disp_o, ready_array_disp_o
  );

  modport master (
    output dispatch_valid_i, new_ar_i, new_pr_i, reg1_ar_i, reg2_ar_i,
           cdb_tag_i, ckpt_take_i, ckpt_way_i, ckpt_release_i,
           recover_en_i, recover_id_i, flush_en_i, archi_maptable_i,
    input  reg1_tag_o, reg2_tag_o, reg1_ready_o, reg2_ready_o, told_out_o,
           ckpt_id_o, ckpt_full_o, map_array_disp_o, ready_array_disp_o
  );
endinterface

// File: rtl/checkpoint_map_table.sv
// WAY-wide register map table with CKPT circular branch snapshots: one-cycle
// mispredict recovery from a snapshot, full flush from the architectural map.
module checkpoint_map_table #(
  parameter int WAY    = 3,
  parameter int AR_NUM = 32,
  parameter int PR_W   = 6,
  parameter int CKPT   = 4,
  parameter int CDB_W  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  checkpoint_map_table_if.slave bus
);
  localparam int AR_W  = $clog2(AR_NUM);
  localparam int WAY_W = (WAY > 1) ? $clog2(WAY) : 1;
  localparam int CK_W  = (CKPT > 1) ? $clog2(CKPT) : 1;
  localparam int CNT_W = CK_W + 1;

  typedef logic [AR_NUM-1:0][PR_W-1:0] map_t;
  typedef logic [AR_NUM-1:0]           rdy_t;
  typedef struct packed {
    logic [PR_W-1:0] tag;
    logic            rdy;
  } look_t;

  map_t             map_q, map_d, cap_map;
  rdy_t             rdy_q, rdy_d, cap_rdy, map_hit;
  map_t             snap_map_q [CKPT];
  rdy_t             snap_rdy_q [CKPT];
  rdy_t             snap_hit   [CKPT];
  logic [CK_W-1:0]  head_q, alloc_q, rec_off;
  logic [CNT_W-1:0] count_q;
  logic             ckpt_full, take_ok, rel_ok;

  logic [WAY-1:0]           dv;
  logic [WAY-1:0][AR_W-1:0] nar;
  logic [WAY-1:0][PR_W-1:0] npr;
  logic [WAY-1:0][PR_W-1:0] r1_tag, r2_tag, told;
  logic [WAY-1:0]           r1_rdy, r2_rdy;

  assign dv  = bus.dispatch_valid_i;
  assign nar = bus.new_ar_i;
  assign npr = bus.new_pr_i;

  assign ckpt_full = (count_q == CNT_W'(CKPT));
  assign take_ok   = bus.ckpt_take_i && !ckpt_full && !bus.flush_en_i && !bus.recover_en_i;
  assign rel_ok    = bus.ckpt_release_i && (count_q != '0) && !bus.flush_en_i && !bus.recover_en_i;
  assign rec_off   = bus.recover_id_i - head_q;

  // CDB match against every live-map and snapshot entry; tag 0 is an idle lane.
  always_comb begin
    map_hit = '0;
    for (int k = 0; k < CKPT; k++) snap_hit[k] = '0;
    for (int c = 0; c < CDB_W; c++) begin
      if (bus.cdb_tag_i[c] != '0) begin
        for (int a = 0; a < AR_NUM; a++) begin
          if (bus.cdb_tag_i[c] == map_q[a]) map_hit[a] = 1'b1;
          for (int k = 0; k < CKPT; k++)
            if (bus.cdb_tag_i[c] == snap_map_q[k][a]) snap_hit[k][a] = 1'b1;
        end
      end
    end
  end

  // Mapping of ar as seen just before `way`: older valid writers override the
  // table, the youngest such writer last.
  function automatic look_t lookup(input logic [AR_W-1:0] ar, input int way);
    look_t r;
    r.tag = map_q[ar];
    r.rdy = rdy_q[ar] | map_hit[ar];
    for (int j = WAY - 1; j > way; j--) begin
      if (dv[j] && nar[j] == ar) begin
        r.tag = npr[j];
        r.rdy = 1'b0;
      end
    end
    if (ar == '0) begin
      r.tag = '0;
      r.rdy = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    look_t l1, l2, lt;
    for (int i = 0; i < WAY; i++) begin
      l1 = lookup(bus.reg1_ar_i[i], i);
      l2 = lookup(bus.reg2_ar_i[i], i);
      lt = lookup(nar[i], i);
      r1_tag[i] = l1.tag;
      r1_rdy[i] = l1.rdy;
      r2_tag[i] = l2.tag;
      r2_rdy[i] = l2.rdy;
      told[i]   = lt.tag;
    end
  end

  // NOTE: blocking assignments here model the ordered oldest-to-youngest
  // application within one cycle; registers below use non-blocking only.
  always_comb begin
    map_d   = map_q;
    rdy_d   = rdy_q | map_hit;
    cap_map = map_d;
    cap_rdy = rdy_d;
    for (int j = WAY - 1; j >= 0; j--) begin
      if (dv[j] && nar[j] != '0) begin
        map_d[nar[j]] = npr[j];
        rdy_d[nar[j]] = 1'b0;
      end
      if (j == int'(bus.ckpt_way_i)) begin
        cap_map = map_d;
        cap_rdy = rdy_d;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AR_NUM; i++) map_q[i] <= PR_W'(i);
      rdy_q   <= '1;
      head_q  <= '0;
      alloc_q <= '0;
      count_q <= '0;
    end else if (bus.flush_en_i) begin
      map_q   <= bus.archi_maptable_i;
      rdy_q   <= '1;
      head_q  <= '0;
      alloc_q <= '0;
      count_q <= '0;
    end else if (bus.recover_en_i) begin
      map_q   <= snap_map_q[bus.recover_id_i];
      rdy_q   <= snap_rdy_q[bus.recover_id_i] | snap_hit[bus.recover_id_i];
      alloc_q <= bus.recover_id_i + CK_W'(1);
      count_q <= CNT_W'(rec_off) + CNT_W'(1);
    end else begin
      map_q   <= map_d;
      rdy_q   <= rdy_d;
      if (take_ok) alloc_q <= alloc_q + CK_W'(1);
      if (rel_ok)  head_q  <= head_q + CK_W'(1);
      count_q <= count_q + CNT_W'(take_ok) - CNT_W'(rel_ok);
    end
  end

  // NOTE: snapshot storage has no reset; only slots between head and alloc
  // are ever read, and reset empties that range through the pointers.
  always_ff @(posedge clock) begin
    for (int k = 0; k < CKPT; k++) snap_rdy_q[k] <= snap_rdy_q[k] | snap_hit[k];
    if (take_ok) begin
      snap_map_q[alloc_q] <= cap_map;
      snap_rdy_q[alloc_q] <= cap_rdy;
    end
  end

  assign bus.reg1_tag_o         = r1_tag;
  assign bus.reg2_tag_o         = r2_tag;
  assign bus.reg1_ready_o       = r1_rdy;
  assign bus.reg2_ready_o       = r2_rdy;
  assign bus.told_out_o         = told;
  assign bus.ckpt_id_o          = alloc_q;
  assign bus.ckpt_full_o        = ckpt_full;
  assign bus.map_array_disp_o   = map_q;
  assign bus.ready_array_disp_o = rdy_q;

  a_no_take_when_full: assert property (@(posedge clock) disable iff (reset)
    !(bus.ckpt_take_i && ckpt_full && !bus.flush_en_i && !bus.recover_en_i));

  a_recover_live: assert property (@(posedge clock) disable iff (reset)
    (bus.recover_en_i && !bus.flush_en_i) |-> (CNT_W'(rec_off) < count_q));
endmodule

// File: tb/tb_checkpoint_map_table.sv
// Bench for checkpoint_map_table: directed scenarios plus randomized traffic
// against a sequential in-order model of rename, checkpoints and recovery.
module tb_checkpoint_map_table;
  localparam int WAY = 3, AR_NUM = 32, PR_W = 6, CKPT = 4, CDB_W = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  checkpoint_map_table_if #(.WAY(WAY), .AR_NUM(AR_NUM), .PR_W(PR_W), .CKPT(CKPT), .CDB_W(CDB_W)) bus ();

  checkpoint_map_table #(.WAY(WAY), .AR_NUM(AR_NUM), .PR_W(PR_W), .CKPT(CKPT), .CDB_W(CDB_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- reference model ----------------
  int m_map [AR_NUM];
  bit m_rdy [AR_NUM];
  int s_map [CKPT][AR_NUM];
  bit s_rdy [CKPT][AR_NUM];
  int m_head, m_alloc, m_count;
  int e_tag1 [WAY], e_tag2 [WAY], e_told [WAY];
  bit e_rdy1 [WAY], e_rdy2 [WAY];
  int n_map [AR_NUM], c_map [AR_NUM];
  bit n_rdy [AR_NUM], c_rdy [AR_NUM];

  function automatic bit cdb_hit(int tag);
    for (int c = 0; c < CDB_W; c++)
      if (tag != 0 && int'(bus.cdb_tag_i[c]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < AR_NUM; a++) begin
      m_map[a] = a;
      m_rdy[a] = 1'b1;
    end
    m_head = 0; m_alloc = 0; m_count = 0;
  endfunction

  // Walk the group oldest to youngest over a working copy of the table:
  // each way sees the table exactly as the older ways have left it.
  function automatic void model_eval();
    int a1, a2, an;
    for (int a = 0; a < AR_NUM; a++) begin
      n_map[a] = m_map[a];
      n_rdy[a] = m_rdy[a] | cdb_hit(m_map[a]);
    end
    c_map = n_map;
    c_rdy = n_rdy;
    for (int i = WAY - 1; i >= 0; i--) begin
      a1 = int'(bus.reg1_ar_i[i]);
      a2 = int'(bus.reg2_ar_i[i]);
      an = int'(bus.new_ar_i[i]);
      e_tag1[i] = (a1 == 0) ? 0 : n_map[a1];
      e_rdy1[i] = (a1 == 0) ? 1'b1 : n_rdy[a1];
      e_tag2[i] = (a2 == 0) ? 0 : n_map[a2];
      e_rdy2[i] = (a2 == 0) ? 1'b1 : n_rdy[a2];
      e_told[i] = (an == 0) ? 0 : n_map[an];
      if (bus.dispatch_valid_i[i] && an != 0) begin
        n_map[an] = int'(bus.new_pr_i[i]);
        n_rdy[an] = 1'b0;
      end
      if (int'(bus.ckpt_way_i) == i) begin
        c_map = n_map;
        c_rdy = n_rdy;
      end
    end
  endfunction

  function automatic void model_step();
    int r_map [AR_NUM];
    bit r_rdy [AR_NUM];
    int id, cnt0;
    model_eval();
    id = int'(bus.recover_id_i);
    for (int a = 0; a < AR_NUM; a++) begin
      r_map[a] = s_map[id][a];
      r_rdy[a] = s_rdy[id][a] | cdb_hit(s_map[id][a]);
    end
    for (int k = 0; k < CKPT; k++)
      for (int a = 0; a < AR_NUM; a++)
        if (cdb_hit(s_map[k][a])) s_rdy[k][a] = 1'b1;
    if (bus.flush_en_i) begin
      for (int a = 0; a < AR_NUM; a++) begin
        m_map[a] = int'(bus.archi_maptable_i[a]);
        m_rdy[a] = 1'b1;
      end
      m_head = 0; m_alloc = 0; m_count = 0;
    end else if (bus.recover_en_i) begin
      m_map   = r_map;
      m_rdy   = r_rdy;
      m_alloc = (id + 1) % CKPT;
      m_count = ((id - m_head + CKPT) % CKPT) + 1;
    end else begin
      m_map = n_map;
      m_rdy = n_rdy;
      cnt0  = m_count;
      if (bus.ckpt_take_i && cnt0 < CKPT) begin
        s_map[m_alloc] = c_map;
        s_rdy[m_alloc] = c_rdy;
        m_alloc = (m_alloc + 1) % CKPT;
        m_count++;
      end
      if (bus.ckpt_release_i && cnt0 > 0) begin
        m_head = (m_head + 1) % CKPT;
        m_count--;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.dispatch_valid_i = '0;
    bus.new_ar_i         = '0;
    bus.new_pr_i         = '0;
    bus.reg1_ar_i        = '0;
    bus.reg2_ar_i        = '0;
    bus.cdb_tag_i        = '0;
    bus.ckpt_take_i      = 1'b0;
    bus.ckpt_way_i       = '0;
    bus.ckpt_release_i   = 1'b0;
    bus.recover_en_i     = 1'b0;
    bus.recover_id_i     = '0;
    bus.flush_en_i       = 1'b0;
  endtask

  task automatic disp(input int way, input int ar, input int pr);
    bus.dispatch_valid_i[way] = 1'b1;
    bus.new_ar_i[way]         = 5'(ar);
    bus.new_pr_i[way]         = PR_W'(pr);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [AR_NUM-1:0][PR_W-1:0] exp_map;
    do_reset();
    #1;
    for (int a = 0; a < AR_NUM; a++) exp_map[a] = PR_W'(a);
    checks++; if (bus.map_array_disp_o !== exp_map) begin errors++; $display("FAIL reset_map got %h want %h", bus.map_array_disp_o, exp_map); end
    checks++; if (bus.ready_array_disp_o !== '1) begin errors++; $display("FAIL reset_ready got %h want all ones", bus.ready_array_disp_o); end
    checks++; if (bus.ckpt_id_o !== 2'd0) begin errors++; $display("FAIL reset_ckpt_id got %0d want 0", bus.ckpt_id_o); end
    checks++; if (bus.ckpt_full_o !== 1'b0) begin errors++; $display("FAIL reset_ckpt_full got %0b want 0", bus.ckpt_full_o); end
  endtask

  task automatic test_forwarding();
    idle();
    disp(2, 1, 33);
    disp(1, 2, 34);
    bus.reg1_ar_i[1] = 5'd1;
    #1;
    checks++; if (bus.reg1_tag_o[1] !== 6'd33) begin errors++; $display("FAIL fwd_tag got %0d want 33", bus.reg1_tag_o[1]); end
    checks++; if (bus.reg1_ready_o[1] !== 1'b0) begin errors++; $display("FAIL fwd_ready got %0b want 0", bus.reg1_ready_o[1]); end
    checks++; if (bus.told_out_o[2] !== 6'd1) begin errors++; $display("FAIL fwd_told2 got %0d want 1", bus.told_out_o[2]); end
    checks++; if (bus.told_out_o[1] !== 6'd2) begin errors++; $display("FAIL fwd_told1 got %0d want 2", bus.told_out_o[1]); end
    tick();
    idle();
    #1;
    checks++; if (bus.map_array_disp_o[1] !== 6'd33) begin errors++; $display("FAIL fwd_map1 got %0d want 33", bus.map_array_disp_o[1]); end
    checks++; if (bus.ready_array_disp_o[1] !== 1'b0) begin errors++; $display("FAIL fwd_rdy1 got %0b want 0", bus.ready_array_disp_o[1]); end
  endtask

  task automatic test_same_ar();
    idle();
    disp(2, 11, 40);
    disp(1, 11, 41);
    disp(0, 11, 42);
    #1;
    checks++; if (bus.told_out_o !== {6'd11, 6'd40, 6'd41}) begin errors++; $display("FAIL same_ar_told got %h want 11,40,41", bus.told_out_o); end
    tick();
    idle();
    #1;
    checks++; if (bus.map_array_disp_o[11] !== 6'd42) begin errors++; $display("FAIL same_ar_map got %0d want 42", bus.map_array_disp_o[11]); end
  endtask

  task automatic test_cdb_bypass();
    idle();
    bus.cdb_tag_i    = {6'd33, 6'd0, 6'd0};
    bus.reg1_ar_i[0] = 5'd1;
    disp(0, 1, 50);
    #1;
    checks++; if (bus.reg1_tag_o[0] !== 6'd33 || bus.reg1_ready_o[0] !== 1'b1) begin errors++; $display("FAIL cdb_bypass got tag %0d rdy %0b want 33/1", bus.reg1_tag_o[0], bus.reg1_ready_o[0]); end
    tick();
    idle();
    #1;
    checks++; if (bus.map_array_disp_o[1] !== 6'd50 || bus.ready_array_disp_o[1] !== 1'b0) begin errors++; $display("FAIL cdb_write_wins got %0d/%0b want 50/0", bus.map_array_disp_o[1], bus.ready_array_disp_o[1]); end
  endtask

  task automatic test_checkpoint_recover();
    idle();
    disp(2, 3, 35);
    disp(0, 4, 36);
    bus.ckpt_take_i = 1'b1;
    bus.ckpt_way_i  = 2'd1;
    #1;
    checks++; if (bus.ckpt_id_o !== 2'd0) begin errors++; $display("FAIL ck_id_before got %0d want 0", bus.ckpt_id_o); end
    tick();
    idle();
    disp(2, 3, 60);
    bus.cdb_tag_i = {6'd0, 6'd0, 6'd35};
    #1;
    checks++; if (bus.ckpt_id_o !== 2'd1) begin errors++; $display("FAIL ck_id_after got %0d want 1", bus.ckpt_id_o); end
    tick();
    idle();
    #1;
    checks++; if (bus.map_array_disp_o[3] !== 6'd60) begin errors++; $display("FAIL ck_newer_map got %0d want 60", bus.map_array_disp_o[3]); end
    bus.recover_en_i = 1'b1;
    bus.recover_id_i = 2'd0;
    tick();
    idle();
    #1;
    checks++; if (bus.map_array_disp_o[3] !== 6'd35 || bus.ready_array_disp_o[3] !== 1'b1) begin errors++; $display("FAIL rec_map3 got %0d/%0b want 35/1", bus.map_array_disp_o[3], bus.ready_array_disp_o[3]); end
    checks++; if (bus.map_array_disp_o[4] !== 6'd4 || bus.ready_array_disp_o[4] !== 1'b1) begin errors++; $display("FAIL rec_map4 got %0d/%0b want 4/1", bus.map_array_disp_o[4], bus.ready_array_disp_o[4]); end
    checks++; if (bus.ckpt_id_o !== 2'd1) begin errors++; $display("FAIL rec_alloc got %0d want 1", bus.ckpt_id_o); end
    bus.ckpt_release_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_ckpt_full();
    do_reset();
    for (int k = 0; k < CKPT; k++) begin
      idle();
      bus.ckpt_take_i = 1'b1;
      #1;
      checks++; if (bus.ckpt_id_o !== 2'(k) || bus.ckpt_full_o !== 1'b0) begin errors++; $display("FAIL fill_%0d got id %0d full %0b", k, bus.ckpt_id_o, bus.ckpt_full_o); end
      tick();
    end
    idle();
    #1;
    checks++; if (bus.ckpt_full_o !== 1'b1 || bus.ckpt_id_o !== 2'd0) begin errors++; $display("FAIL full_flag got full %0b id %0d want 1/0", bus.ckpt_full_o, bus.ckpt_id_o); end
    bus.ckpt_release_i = 1'b1;
    tick();
    idle();
    disp(2, 7, 45);
    bus.ckpt_way_i     = 2'd2;
    bus.ckpt_take_i    = 1'b1;
    bus.ckpt_release_i = 1'b1;
    #1;
    checks++; if (bus.ckpt_full_o !== 1'b0) begin errors++; $display("FAIL after_release got full %0b want 0", bus.ckpt_full_o); end
    tick();
    idle();
    #1;
    checks++; if (bus.ckpt_full_o !== 1'b0 || bus.ckpt_id_o !== 2'd1) begin errors++; $display("FAIL take_release got full %0b id %0d want 0/1", bus.ckpt_full_o, bus.ckpt_id_o); end
    disp(2, 7, 46);
    bus.ckpt_way_i  = 2'd2;
    bus.ckpt_take_i = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (bus.ckpt_full_o !== 1'b1 || bus.ckpt_id_o !== 2'd2) begin errors++; $display("FAIL refill got full %0b id %0d want 1/2", bus.ckpt_full_o, bus.ckpt_id_o); end
    repeat (2) begin
      bus.ckpt_release_i = 1'b1;
      tick();
      idle();
    end
    bus.recover_en_i = 1'b1;
    bus.recover_id_i = 2'd0;
    tick();
    idle();
    #1;
    checks++; if (bus.map_array_disp_o[7] !== 6'd45 || bus.ckpt_id_o !== 2'd1) begin errors++; $display("FAIL wrap_recover got map7 %0d id %0d want 45/1", bus.map_array_disp_o[7], bus.ckpt_id_o); end
    repeat (3) begin
      bus.ckpt_take_i = 1'b1;
      tick();
      idle();
    end
    #1;
    checks++; if (bus.ckpt_full_o !== 1'b1) begin errors++; $display("FAIL wrap_count got full %0b want 1", bus.ckpt_full_o); end
  endtask

  task automatic test_flush();
    idle();
    for (int a = 0; a < AR_NUM; a++) bus.archi_maptable_i[a] = PR_W'(a);
    bus.archi_maptable_i[5] = 6'd20;
    bus.flush_en_i   = 1'b1;
    bus.recover_en_i = 1'b1;
    bus.recover_id_i = 2'd1;
    disp(2, 5, 50);
    tick();
    idle();
    bus.reg1_ar_i[0] = 5'd5;
    #1;
    checks++; if (bus.map_array_disp_o[5] !== 6'd20 || bus.ready_array_disp_o !== '1) begin errors++; $display("FAIL flush_map got %0d rdy %h want 20/all", bus.map_array_disp_o[5], bus.ready_array_disp_o); end
    checks++; if (bus.ckpt_full_o !== 1'b0 || bus.ckpt_id_o !== 2'd0) begin errors++; $display("FAIL flush_ptrs got full %0b id %0d want 0/0", bus.ckpt_full_o, bus.ckpt_id_o); end
    checks++; if (bus.reg1_tag_o[0] !== 6'd20 || bus.reg1_ready_o[0] !== 1'b1) begin errors++; $display("FAIL flush_lookup got %0d/%0b want 20/1", bus.reg1_tag_o[0], bus.reg1_ready_o[0]); end
  endtask

  task automatic test_random();
    bit map_ok;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      for (int i = 0; i < WAY; i++) begin
        bus.dispatch_valid_i[i] = 1'($urandom_range(0, 1));
        bus.new_ar_i[i]  = 5'($urandom_range(0, 7));
        bus.new_pr_i[i]  = PR_W'($urandom_range(1, 63));
        bus.reg1_ar_i[i] = 5'($urandom_range(0, 9));
        bus.reg2_ar_i[i] = 5'($urandom_range(0, 9));
      end
      for (int c = 0; c < CDB_W; c++)
        bus.cdb_tag_i[c] = ($urandom_range(0, 1) == 1) ? PR_W'($urandom_range(1, 63)) : '0;
      bus.ckpt_way_i     = 2'($urandom_range(0, WAY - 1));
      bus.ckpt_take_i    = (m_count < CKPT) && ($urandom_range(0, 2) == 0);
      bus.ckpt_release_i = (m_count > 0) && ($urandom_range(0, 3) == 0);
      if (m_count > 0 && $urandom_range(0, 11) == 0) begin
        bus.recover_en_i = 1'b1;
        bus.recover_id_i = 2'((m_head + $urandom_range(0, m_count - 1)) % CKPT);
      end
      if ($urandom_range(0, 79) == 0) begin
        bus.flush_en_i = 1'b1;
        for (int a = 0; a < AR_NUM; a++) bus.archi_maptable_i[a] = (a == 0) ? '0 : PR_W'($urandom_range(1, 63));
      end
      #1;
      model_eval();
      for (int i = 0; i < WAY; i++) begin
        checks++; if (bus.reg1_tag_o[i] !== PR_W'(e_tag1[i]) || bus.reg1_ready_o[i] !== e_rdy1[i]) begin errors++; $display("FAIL rnd_reg1 cyc %0d way %0d got %0d/%0b want %0d/%0b", cyc, i, bus.reg1_tag_o[i], bus.reg1_ready_o[i], e_tag1[i], e_rdy1[i]); end
        checks++; if (bus.reg2_tag_o[i] !== PR_W'(e_tag2[i]) || bus.reg2_ready_o[i] !== e_rdy2[i]) begin errors++; $display("FAIL rnd_reg2 cyc %0d way %0d got %0d/%0b want %0d/%0b", cyc, i, bus.reg2_tag_o[i], bus.reg2_ready_o[i], e_tag2[i], e_rdy2[i]); end
        checks++; if (bus.told_out_o[i] !== PR_W'(e_told[i])) begin errors++; $display("FAIL rnd_told cyc %0d way %0d got %0d want %0d", cyc, i, bus.told_out_o[i], e_told[i]); end
      end
      map_ok = 1'b1;
      for (int a = 0; a < AR_NUM; a++)
        if (bus.map_array_disp_o[a] !== PR_W'(m_map[a]) || bus.ready_array_disp_o[a] !== m_rdy[a]) map_ok = 1'b0;
      checks++; if (!map_ok) begin errors++; $display("FAIL rnd_map cyc %0d got %h / %h", cyc, bus.map_array_disp_o, bus.ready_array_disp_o); end
      checks++; if (bus.ckpt_id_o !== 2'(m_alloc) || bus.ckpt_full_o !== (m_count == CKPT)) begin errors++; $display("FAIL rnd_ckpt cyc %0d got id %0d full %0b want %0d/%0b", cyc, bus.ckpt_id_o, bus.ckpt_full_o, m_alloc, m_count == CKPT); end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic [AR_NUM-1:0][PR_W-1:0] exp_map;
    idle();
    bus.ckpt_take_i = (m_count < CKPT);
    disp(2, 6, 55);
    tick();
    idle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int a = 0; a < AR_NUM; a++) exp_map[a] = PR_W'(a);
    checks++; if (bus.map_array_disp_o !== exp_map || bus.ready_array_disp_o !== '1) begin errors++; $display("FAIL async_reset_map got %h / %h", bus.map_array_disp_o, bus.ready_array_disp_o); end
    checks++; if (bus.ckpt_id_o !== 2'd0 || bus.ckpt_full_o !== 1'b0) begin errors++; $display("FAIL async_reset_ptrs got id %0d full %0b want 0/0", bus.ckpt_id_o, bus.ckpt_full_o); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    bus.archi_maptable_i = '0;
    test_reset();
    test_forwarding();
    test_same_ar();
    test_cdb_bypass();
    test_checkpoint_recover();
    test_ckpt_full();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
